// File: rtl/ik_swift_sequencer.sv
// ---------------------------------------------------------------------------
// ik_swift_sequencer
//   Iteration controller for the ik_swift damped-least-squares solver.
//   Accepts one solve request (target, initial DH params, tolerance), runs the
//   solver pass after pass, feeding each pass's dh_dyn_out back as the next
//   pass's dh_dyn_in. The solve stops on convergence (every |delta| < tol),
//   on the iteration cap, on a solver timeout, or on abort.
//
//   Optional feature: define IK_SEQ_PERF_EN to add the cycle_count output
//   (busy-cycle counter, saturating at 2^32-1).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      request pulse (taken in IDLE only) / cancel in-flight solve
//   target_in, dh_init, tol   request data, captured on an accepted start
//   slv_en, slv_rst   solver enable (high for a whole pass) / solver reset (active high)
//   slv_target, slv_dh_dyn    registered operands driven to the solver
//   slv_done, slv_delta, slv_dh_out  solver pass result
//   busy, done, status, iter_count, dh_result  host-side result
//   cycle_count       (IK_SEQ_PERF_EN only) cycles spent busy in the current/last solve
// ---------------------------------------------------------------------------

// Per-lane convergence test: |delta| < tol, with the most negative value
// treated as never converging (its negation does not fit in W bits).
module ik_swift_seq_lane_conv #(
    parameter int W = 36
) (
    input  logic [W-1:0] delta,
    input  logic [W-1:0] tol,
    output logic         lt
);
    logic         is_min;
    logic [W-1:0] mag;

    always_comb begin
        is_min = (delta == {1'b1, {(W-1){1'b0}}});
        mag    = delta[W-1] ? (~delta + {{(W-1){1'b0}}, 1'b1}) : delta;
        lt     = !is_min && (mag < tol);
    end
endmodule

module ik_swift_sequencer #(
    parameter int MAX_ITER = 64,
    parameter int TIMEOUT  = 4096,
    parameter int ITER_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [5:0][35:0]                target_in,
    input  logic [5:0][20:0]                dh_init,
    input  logic [35:0]                     tol,
    output logic                            slv_en,
    output logic                            slv_rst,
    output logic [5:0][35:0]                slv_target,
    output logic [5:0][20:0]                slv_dh_dyn,
    input  logic                            slv_done,
    input  logic [5:0][35:0]                slv_delta,
    input  logic [5:0][20:0]                slv_dh_out,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      status,
    output logic [ITER_W-1:0]               iter_count,
    output logic [5:0][20:0]                dh_result
`ifdef IK_SEQ_PERF_EN
    ,
    output logic [31:0]                     cycle_count
`endif
);
    localparam int NUM_LANES = 6;
    localparam int WAIT_W    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_CONV  = 2'd0;
    localparam logic [1:0] ST_CAP   = 2'd1;
    localparam logic [1:0] ST_TMO   = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRST,
        S_RUN,
        S_CHECK,
        S_FIN
    } state_e;

    state_e                  state_q, state_d;
    logic                    slv_en_q, slv_en_d;
    logic                    slv_rst_q, slv_rst_d;
    logic [5:0][35:0]        target_q, target_d;
    logic [5:0][20:0]        dh_dyn_q, dh_dyn_d;
    logic [35:0]             tol_q, tol_d;
    logic [5:0][35:0]        delta_q, delta_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [1:0]              status_q, status_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [5:0][20:0]        dh_res_q, dh_res_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
`ifdef IK_SEQ_PERF_EN
    logic [31:0]             cyc_q, cyc_d;
`endif

    logic [NUM_LANES-1:0]    lane_lt;
    logic                    conv;

    // Convergence is evaluated on the deltas captured at slv_done, one lane each.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        ik_swift_seq_lane_conv #(.W(36)) u_conv (
            .delta (delta_q[i]),
            .tol   (tol_q),
            .lt    (lane_lt[i])
        );
    end

    assign conv = &lane_lt;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dh_dyn_d = dh_dyn_q;
        tol_d    = tol_q;
        delta_d  = delta_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        status_d = status_q;
        iter_d   = iter_q;
        dh_res_d = dh_res_q;
        wait_d   = wait_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d = target_in;
                    dh_dyn_d = dh_init;
                    tol_d    = tol;
                    iter_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SRST;
                end
            end
            S_SRST: begin
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_FIN;
                end else begin
                    wait_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // abort outranks a same-cycle slv_done: nothing is captured
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_FIN;
                end else if (slv_done) begin
                    delta_d  = slv_delta;
                    dh_res_d = slv_dh_out;
                    dh_dyn_d = slv_dh_out;
                    iter_d   = iter_q + 1'b1;
                    state_d  = S_CHECK;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // this is the TIMEOUT-th RUN cycle without a result
                    status_d = ST_TMO;
                    state_d  = S_FIN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_FIN;
                end else if (conv) begin
                    status_d = ST_CONV;
                    state_d  = S_FIN;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    status_d = ST_CAP;
                    state_d  = S_FIN;
                end else begin
                    state_d = S_SRST;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Solver controls are registered from the next state so they line up
        // with the state they belong to.
        slv_en_d  = (state_d == S_RUN);
        slv_rst_d = (state_d == S_IDLE) || (state_d == S_SRST) || (state_d == S_FIN);
    end

`ifdef IK_SEQ_PERF_EN
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && start) begin
            cyc_d = '0;
        end else if (busy_q && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            slv_en_q  <= 1'b0;
            slv_rst_q <= 1'b1;
            target_q  <= '0;
            dh_dyn_q  <= '0;
            tol_q     <= '0;
            delta_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= ST_CONV;
            iter_q    <= '0;
            dh_res_q  <= '0;
            wait_q    <= '0;
`ifdef IK_SEQ_PERF_EN
            cyc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            slv_en_q  <= slv_en_d;
            slv_rst_q <= slv_rst_d;
            target_q  <= target_d;
            dh_dyn_q  <= dh_dyn_d;
            tol_q     <= tol_d;
            delta_q   <= delta_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            status_q  <= status_d;
            iter_q    <= iter_d;
            dh_res_q  <= dh_res_d;
            wait_q    <= wait_d;
`ifdef IK_SEQ_PERF_EN
            cyc_q     <= cyc_d;
`endif
        end
    end

    assign slv_en     = slv_en_q;
    assign slv_rst    = slv_rst_q;
    assign slv_target = target_q;
    assign slv_dh_dyn = dh_dyn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign iter_count = iter_q;
    assign dh_result  = dh_res_q;
`ifdef IK_SEQ_PERF_EN
    assign cycle_count = cyc_q;
`endif

endmodule
